// File: rtl/cover_toggle_drain.sv
// cover_toggle_drain: collects per-cycle toggle-cover strobes, keeps a sticky
// "seen" bitmap, queues first-time hits in a pending bitmap and drains them one
// per cycle as global cover indices over a valid/ready stream.
//
// Ports:
//   clock          sole clock, rising-edge
//   reset          asynchronous active-low reset
//   valid          [WIDTH]  per-cycle cover strobes
//   clear_seen     re-arms all points (synchronous pulse)
//   out_valid      out_index holds a pending cover event (registered)
//   out_ready      consumer accepts when out_valid & out_ready at an edge
//   out_index      [64]     COVER_INDEX + bit position (registered)
//   covered_count  [CNT_W]  distinct points seen since reset/clear (registered)
//   idle           no pending work and no event presented (from state only)
module cover_toggle_drain #(
    parameter int unsigned WIDTH       = 64,
    parameter logic [63:0] COVER_INDEX = 64'd0,
    parameter int unsigned CNT_W       = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  valid,
    input  logic              clear_seen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_index,
    output logic [CNT_W-1:0]  covered_count,
    output logic              idle
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] seen;
    logic [WIDTH-1:0] pending;

    logic [WIDTH-1:0] seen_eff;
    logic [WIDTH-1:0] new_hits;
    logic [WIDTH-1:0] seen_nxt;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] pick;
    logic [WIDTH-1:0] pending_nxt;
    logic [IDX_W-1:0] pick_idx;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] count_nxt;
    logic             load;
    logic             out_valid_nxt;
    logic [63:0]      out_index_nxt;

    // Next-state: first-hit detection, popcount, lowest-bit pick, output load.
    always_comb begin
        seen_eff      = clear_seen ? '0 : seen;
        new_hits      = valid & ~seen_eff;
        seen_nxt      = seen_eff | valid;
        cand          = pending | new_hits;
        // Isolate the lowest set bit: bit 0 has highest priority.
        pick          = cand & (~cand + WIDTH'(1));

        hit_cnt  = '0;
        pick_idx = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            hit_cnt = hit_cnt + CNT_W'(new_hits[i]);
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end

        count_nxt = (clear_seen ? '0 : covered_count) + hit_cnt;

        // Output slot is free or being accepted this edge.
        load          = !out_valid || out_ready;

        out_valid_nxt = out_valid;
        out_index_nxt = out_index;
        pending_nxt   = cand;
        if (load) begin
            pending_nxt   = cand & ~pick;
            out_valid_nxt = |cand;
            if (|cand) begin
                out_index_nxt = COVER_INDEX + 64'(pick_idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seen          <= '0;
            pending       <= '0;
            out_valid     <= 1'b0;
            out_index     <= '0;
            covered_count <= '0;
        end else begin
            seen          <= seen_nxt;
            pending       <= pending_nxt;
            out_valid     <= out_valid_nxt;
            out_index     <= out_index_nxt;
            covered_count <= count_nxt;
        end
    end

    assign idle = (pending == '0) && !out_valid;

endmodule

// File: tb/tb_cover_toggle_drain.sv
// Bench for cover_toggle_drain: directed steps plus random traffic, checked
// against a set-based reference model of seen/pending points.
module tb_cover_toggle_drain;

    localparam int unsigned W     = 64;
    localparam logic [63:0] BASE  = 64'd100;

    logic          clock;
    logic          reset;
    logic [W-1:0]  valid;
    logic          clear_seen;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_index;
    logic [6:0]    covered_count;
    logic          idle;

    cover_toggle_drain #(.WIDTH(W), .COVER_INDEX(BASE), .CNT_W(7)) dut (
        .clock         (clock),
        .reset         (reset),
        .valid         (valid),
        .clear_seen    (clear_seen),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .covered_count (covered_count),
        .idle          (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: sets of seen and pending points, the presented event.
    bit          m_seen [W];
    bit          m_pend [W];
    bit          m_ov;
    logic [63:0] m_idx;
    int          m_count;
    logic [63:0] acc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pend_cnt();
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic bit m_idle();
        return (pend_cnt() == 0) && !m_ov;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_seen[i] = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_ov    = 1'b0;
        m_idx   = '0;
        m_count = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] v, input logic clr, input logic rdy);
        int k;
        if (m_ov && rdy) acc.push_back(m_idx);
        if (clr) begin
            m_count = 0;
            for (int i = 0; i < W; i++) m_seen[i] = 1'b0;
        end
        for (int i = 0; i < W; i++) begin
            if (v[i] && !m_seen[i]) begin
                m_seen[i] = 1'b1;
                m_count++;
                m_pend[i] = 1'b1;
            end
        end
        if (!m_ov || rdy) begin
            k = -1;
            for (int i = W - 1; i >= 0; i--) if (m_pend[i]) k = i;
            if (k >= 0) begin
                m_ov      = 1'b1;
                m_idx     = BASE + 64'(k);
                m_pend[k] = 1'b0;
            end else begin
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic chk_all();
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_index", out_index, m_idx);
        chk("covered_count", 64'(covered_count), 64'(m_count));
        chk("idle", 64'(idle), 64'(m_idle()));
    endtask

    task automatic step(input logic [W-1:0] v, input logic clr, input logic rdy);
        valid      = v;
        clear_seen = clr;
        out_ready  = rdy;
        @(posedge clock);
        model_edge(v, clr, rdy);
        #1;
        chk_all();
    endtask

    initial begin
        int n0;
        int n;
        logic [W-1:0] ones;
        logic [W-1:0] rv;

        ones       = '1;
        valid      = '0;
        clear_seen = 1'b0;
        out_ready  = 1'b1;
        reset      = 1'b0;
        model_reset();
        #2;
        chk_all();
        #10 reset = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) step('0, 1'b0, 1'b1);

        // Two hits, drained in ascending order; repeats suppressed.
        n0 = acc.size();
        step(64'h5, 1'b0, 1'b1);
        chk("first_idx", out_index, 64'd100);
        step('0, 1'b0, 1'b1);
        chk("second_idx", out_index, 64'd102);
        step('0, 1'b0, 1'b1);
        chk("drop_valid", 64'(out_valid), 64'd0);
        chk("count_two", 64'(covered_count), 64'd2);
        step(64'h5, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step('0, 1'b0, 1'b1);
        chk("repeat_suppressed", 64'(acc.size() - n0), 64'd2);

        // Backpressure: event held stable, then drains 100 then 163.
        n0 = acc.size();
        step(64'h8000_0000_0000_0001, 1'b1, 1'b0);
        step(64'h8000_0000_0000_0001, 1'b0, 1'b0);
        step(64'h8000_0000_0000_0001, 1'b0, 1'b0);
        chk("held_idx", out_index, 64'd100);
        for (int i = 0; i < 4; i++) step('0, 1'b0, 1'b1);
        chk("bp_events", 64'(acc.size() - n0), 64'd2);
        chk("bp_first", acc[n0], 64'd100);
        chk("bp_second", acc[n0 + 1], 64'd163);
        chk("bp_count", 64'(covered_count), 64'd2);

        // clear_seen with a re-hit of point 0.
        n0 = acc.size();
        step(64'h1, 1'b1, 1'b1);
        chk("clr_count", 64'(covered_count), 64'd1);
        for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b1);
        chk("clr_events", 64'(acc.size() - n0), 64'd1);
        chk("clr_idx", acc[n0], 64'd100);

        // All-ones burst with random ready.
        n0 = acc.size();
        step(ones, 1'b1, 1'($urandom_range(0, 1)));
        n = 0;
        while (!m_idle() && n < 600) begin
            step('0, 1'b0, 1'($urandom_range(0, 1)));
            n++;
        end
        chk("burst_timeout", 64'(n < 600), 64'd1);
        chk("burst_events", 64'(acc.size() - n0), 64'd64);
        for (int i = 0; i < 64 && n0 + i < acc.size(); i++)
            chk("burst_order", acc[n0 + i], BASE + 64'(i));
        chk("burst_idle", 64'(idle), 64'd1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            rv = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            step(rv, 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));
        end

        // Reset mid-drain with 10 points pending.
        step(ones, 1'b1, 1'b1);
        n = 0;
        while (pend_cnt() > 10 && n < 200) begin
            step('0, 1'b0, 1'b1);
            n++;
        end
        chk("pend_ten", 64'(pend_cnt()), 64'd10);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk_all();
        #4 reset = 1'b1;
        n0 = acc.size();
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b1);
        chk("post_reset_quiet", 64'(acc.size() - n0), 64'd0);
        step(64'h10, 1'b0, 1'b1);
        chk("post_reset_hit", out_index, 64'd104);
        step('0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
